if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register of the pipelined MIPS core; directly upstream of Decoder.
//  Holds the PC, drives the combinational instruction memory, and registers instruction/PC+4 for ID.
//  instr_op_o (= registered instr[31:26]) feeds Decoder instr_op_i.
//  Handles stall, branch/jump redirect, flush bubbles and a halt state.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  HALT_WORD  32'hFFFF_FFFF  instruction encoding that halts fetch
//  NOP_WORD   32'h0000_0000  bubble inserted into IF/ID (sll $0,$0,0)
// PORTS
//  clk_i            in   1   clock, all state updates on rising edge
//  rst_i            in   1   synchronous active-low reset
//  stall_i          in   1   hazard-unit stall: hold PC and IF/ID
//  flush_i          in   1   force bubble into IF/ID next edge
//  branch_taken_i   in   1   EX-stage taken branch
//  branch_target_i  in   32  branch target byte address
//  jump_i           in   1   ID-stage jump (Decoder Jump_o)
//  jump_index_i     in   26  instr[25:0] of jump in ID
//  imem_addr_o      out  32  = pc; word-aligned byte address
//  imem_data_i      in   32  instruction at imem_addr_o, same cycle
//  pc_o             out  32  current PC
//  if_id_instr_o    out  32  registered instruction
//  if_id_pc4_o      out  32  registered PC+4
//  if_id_valid_o    out  1   1 = IF/ID holds real instruction
//  instr_op_o       out  6   if_id_instr_o[31:26]
//  halted_o         out  1   1 while FSM in HALT
// BEHAVIOUR
//  Reset (rst_i==0 at edge): pc=RESET_PC, if_id_instr=NOP_WORD, if_id_pc4=0, valid=0, halted=0, state=BOOT.
//  FSM: BOOT -> RUN unconditionally next edge (IF/ID stays bubble, PC not advanced in BOOT).
//   RUN -> HALT when imem_data_i==HALT_WORD and no redirect/stall that edge; HALT word itself not loaded into IF/ID (bubble).
//   HALT -> RUN only on branch_taken_i (halt was wrong-path); otherwise PC frozen, IF/ID bubbles, halted_o=1.
//  Next-PC priority per edge (RUN or HALT):
//   1 branch_taken_i: pc<=branch_target_i; IF/ID<=bubble. Overrides stall_i, jump_i, halt.
//   2 jump_i: pc<={if_id_pc4_o[31:28],jump_index_i,2'b00}; IF/ID<=bubble. Overrides stall_i.
//   3 stall_i: pc and IF/ID hold (flush_i still bubbles IF/ID).
//   4 else: pc<=pc+4 (mod 2^32, wraps FFFF_FFFC->0); IF/ID<={imem_data_i,pc+4}, valid=1.
//  flush_i: IF/ID<=bubble regardless of stall; PC follows priority above.
//  Latency: instruction at pc visible on if_id_* one edge later. Bubble = NOP_WORD, pc4=0, valid=0.
//  branch_target_i[1:0] and jump-derived low bits are forced 00.
//  Reset mid-operation: overrides everything, same values as above.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds outputs fetch_cnt_o[31:0] (+1 per edge loading valid=1)
//   and bubble_cnt_o[31:0] (+1 per edge loading valid=0 outside BOOT); both reset 0, wrap.
//  Not defined: ports and counters absent; remaining behaviour identical.
// TESTING
//  reset, imem returns 0x2008_0005 at 0 -> edge1 BOOT valid=0, pc=0; edge2 if_id_instr=0x2008_0005, pc4=4, instr_op=6'b001000.
//  stall_i=1 two cycles at pc=8 -> pc stays 8, if_id unchanged; release -> pc=C.
//  branch_taken_i=1 target 0x40 with stall_i=1 -> pc=0x40, valid=0 next edge.
//  jump_i=1 index 0x000010, if_id_pc4=0x1000_0008 -> pc=0x1000_0040, bubble.
//  imem=HALT_WORD at 0x20 -> halted_o=1, pc stays 0x20; branch to 0x80 -> RUN, pc=0x80.
//  pc=FFFF_FFFC sequential -> pc=0, if_id_pc4=0; rst_i=0 mid-run -> all outputs reset values.

Source files
------------

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : MIPS fetch stage with IF/ID register; optional IF_PERF_CNT_EN
//            macro adds fetch/bubble counters.
// Revision : 1.0
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc4_o,
  output logic        if_id_valid_o,
  output logic [5:0]  instr_op_o,
  output logic        halted_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_pc;
  logic [31:0] jump_pc;
  logic        bubble;
  logic        fetch;

  assign pc_plus4  = pc_q + 32'd4;
  assign branch_pc = {branch_target_i[31:2], 2'b00};
  assign jump_pc   = {pc4_q[31:28], jump_index_i, 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    bubble  = 1'b0;
    fetch   = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        bubble  = 1'b1;
      end
      ST_RUN: begin
        if (branch_taken_i) begin
          pc_d   = branch_pc;
          bubble = 1'b1;
        end else if (jump_i) begin
          pc_d   = jump_pc;
          bubble = 1'b1;
        end else if (stall_i) begin
          bubble = flush_i;
        end else if (imem_data_i == HALT_WORD) begin
          // The halt word never reaches ID; PC parks on it.
          state_d = ST_HALT;
          bubble  = 1'b1;
        end else begin
          pc_d   = pc_plus4;
          bubble = flush_i;
          fetch  = ~flush_i;
        end
      end
      ST_HALT: begin
        bubble = 1'b1;
        if (branch_taken_i) begin
          state_d = ST_RUN;
          pc_d    = branch_pc;
        end
      end
      default: begin
        state_d = ST_BOOT;
        bubble  = 1'b1;
      end
    endcase

    if (bubble) begin
      instr_d = NOP_WORD;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (fetch) begin
      instr_d = imem_data_i;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + {31'd0, fetch};
    bubble_cnt_d = bubble_cnt_q + {31'd0, (bubble && (state_q != ST_BOOT))};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt_o  = fetch_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign if_id_instr_o = instr_q;
  assign if_id_pc4_o   = pc4_q;
  assign if_id_valid_o = valid_q;
  assign instr_op_o    = instr_q[31:26];
  assign halted_o      = (state_q == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Directed self-checking bench for if_stage.
// Revision : 1.0
// ============================================================================
module tb_if_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        flush_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        jump_i;
  logic [25:0] jump_index_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] pc_o;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc4_o;
  logic        if_id_valid_o;
  logic [5:0]  instr_op_o;
  logic        halted_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] bubble_cnt_o;
`endif

  logic [31:0] mem [64];
  int checks = 0;
  int errors = 0;

  assign imem_data_i = mem[imem_addr_o[7:2]];

  always #5 clk_i = ~clk_i;

  if_stage dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_index_i    (jump_index_i),
    .imem_addr_o     (imem_addr_o),
    .imem_data_i     (imem_data_i),
    .pc_o            (pc_o),
    .if_id_instr_o   (if_id_instr_o),
    .if_id_pc4_o     (if_id_pc4_o),
    .if_id_valid_o   (if_id_valid_o),
    .instr_op_o      (instr_op_o),
    .halted_o        (halted_o)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt_o     (fetch_cnt_o),
    .bubble_cnt_o    (bubble_cnt_o)
`endif
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    stall_i         = 1'b0;
    flush_i         = 1'b0;
    branch_taken_i  = 1'b0;
    branch_target_i = 32'd0;
    jump_i          = 1'b0;
    jump_index_i    = 26'd0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    idle_inputs();
    tick();
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc_o, 32'h0); end
    checks++; if (if_id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if_id_valid_o); end
    checks++; if (if_id_instr_o !== 32'h0 || if_id_pc4_o !== 32'h0) begin errors++; $display("FAIL reset_ifid got %h/%h exp 0/0", if_id_instr_o, if_id_pc4_o); end
    checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted_o); end
    rst_i = 1'b1;
    tick();
    checks++; if (pc_o !== 32'h0 || if_id_valid_o !== 1'b0) begin errors++; $display("FAIL boot got pc %h valid %b exp 0/0", pc_o, if_id_valid_o); end
    tick();
    checks++; if (if_id_instr_o !== 32'h2008_0005 || if_id_pc4_o !== 32'h4 || if_id_valid_o !== 1'b1) begin
      errors++; $display("FAIL first_fetch got %h/%h/%b exp 20080005/00000004/1", if_id_instr_o, if_id_pc4_o, if_id_valid_o); end
    checks++; if (instr_op_o !== 6'b001000 || pc_o !== 32'h4) begin errors++; $display("FAIL first_op got op %b pc %h exp 001000/4", instr_op_o, pc_o); end
  endtask

  task automatic test_stall();
    tick();
    checks++; if (pc_o !== 32'h8 || if_id_pc4_o !== 32'h8 || if_id_instr_o !== 32'h2000_0001) begin
      errors++; $display("FAIL seq got pc %h pc4 %h instr %h exp 8/8/20000001", pc_o, if_id_pc4_o, if_id_instr_o); end
    stall_i = 1'b1;
    tick();
    tick();
    checks++; if (pc_o !== 32'h8 || if_id_pc4_o !== 32'h8 || if_id_instr_o !== 32'h2000_0001 || if_id_valid_o !== 1'b1) begin
      errors++; $display("FAIL stall_hold got pc %h pc4 %h instr %h exp 8/8/20000001", pc_o, if_id_pc4_o, if_id_instr_o); end
    stall_i = 1'b0;
    tick();
    checks++; if (pc_o !== 32'hC || if_id_instr_o !== 32'h2000_0002 || if_id_pc4_o !== 32'hC) begin
      errors++; $display("FAIL stall_release got pc %h instr %h pc4 %h exp C/20000002/C", pc_o, if_id_instr_o, if_id_pc4_o); end
  endtask

  task automatic test_flush();
    stall_i = 1'b1; flush_i = 1'b1;
    tick();
    checks++; if (pc_o !== 32'hC || if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0) begin
      errors++; $display("FAIL flush_stall got pc %h valid %b instr %h exp C/0/0", pc_o, if_id_valid_o, if_id_instr_o); end
    stall_i = 1'b0;
    tick();
    checks++; if (pc_o !== 32'h10 || if_id_valid_o !== 1'b0 || if_id_pc4_o !== 32'h0) begin
      errors++; $display("FAIL flush_run got pc %h valid %b pc4 %h exp 10/0/0", pc_o, if_id_valid_o, if_id_pc4_o); end
    flush_i = 1'b0;
  endtask

  task automatic test_branch();
    stall_i = 1'b1; jump_i = 1'b1; jump_index_i = 26'h3;
    branch_taken_i = 1'b1; branch_target_i = 32'h0000_0043;
    tick();
    idle_inputs();
    checks++; if (pc_o !== 32'h40 || if_id_valid_o !== 1'b0) begin
      errors++; $display("FAIL branch got pc %h valid %b exp 40/0", pc_o, if_id_valid_o); end
  endtask

  task automatic test_jump();
    branch_taken_i = 1'b1; branch_target_i = 32'h1000_0004;
    tick();
    idle_inputs();
    tick();
    checks++; if (pc_o !== 32'h1000_0008 || if_id_pc4_o !== 32'h1000_0008 || if_id_instr_o !== 32'h2000_0001) begin
      errors++; $display("FAIL jump_setup got pc %h pc4 %h instr %h exp 10000008/10000008/20000001", pc_o, if_id_pc4_o, if_id_instr_o); end
    jump_i = 1'b1; jump_index_i = 26'h000010; stall_i = 1'b1;
    tick();
    idle_inputs();
    checks++; if (pc_o !== 32'h1000_0040 || if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0) begin
      errors++; $display("FAIL jump got pc %h valid %b instr %h exp 10000040/0/0", pc_o, if_id_valid_o, if_id_instr_o); end
  endtask

  task automatic test_halt();
    mem[8] = 32'hFFFF_FFFF;
    branch_taken_i = 1'b1; branch_target_i = 32'h18;
    tick();
    idle_inputs();
    tick();
    tick();
    checks++; if (pc_o !== 32'h20 || if_id_instr_o !== 32'h2000_0007 || halted_o !== 1'b0) begin
      errors++; $display("FAIL pre_halt got pc %h instr %h halted %b exp 20/20000007/0", pc_o, if_id_instr_o, halted_o); end
    tick();
    checks++; if (halted_o !== 1'b1 || pc_o !== 32'h20 || if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0) begin
      errors++; $display("FAIL halt got halted %b pc %h valid %b instr %h exp 1/20/0/0", halted_o, pc_o, if_id_valid_o, if_id_instr_o); end
    jump_i = 1'b1; jump_index_i = 26'h55;
    tick();
    tick();
    idle_inputs();
    checks++; if (halted_o !== 1'b1 || pc_o !== 32'h20) begin
      errors++; $display("FAIL halt_hold got halted %b pc %h exp 1/20", halted_o, pc_o); end
    branch_taken_i = 1'b1; branch_target_i = 32'h80;
    tick();
    idle_inputs();
    checks++; if (halted_o !== 1'b0 || pc_o !== 32'h80 || if_id_valid_o !== 1'b0) begin
      errors++; $display("FAIL halt_exit got halted %b pc %h valid %b exp 0/80/0", halted_o, pc_o, if_id_valid_o); end
    tick();
    checks++; if (pc_o !== 32'h84 || if_id_instr_o !== 32'h2000_0020 || if_id_pc4_o !== 32'h84) begin
      errors++; $display("FAIL resume got pc %h instr %h pc4 %h exp 84/20000020/84", pc_o, if_id_instr_o, if_id_pc4_o); end
    mem[8] = 32'h2000_0008;
  endtask

  task automatic test_wrap();
    branch_taken_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
    tick();
    idle_inputs();
    checks++; if (pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup got pc %h exp FFFFFFFC", pc_o); end
    tick();
    checks++; if (pc_o !== 32'h0 || if_id_pc4_o !== 32'h0 || if_id_valid_o !== 1'b1 || if_id_instr_o !== 32'h2000_003F) begin
      errors++; $display("FAIL wrap got pc %h pc4 %h valid %b instr %h exp 0/0/1/2000003F", pc_o, if_id_pc4_o, if_id_valid_o, if_id_instr_o); end
  endtask

  task automatic test_reset_mid();
    tick();
    tick();
    mem[4] = 32'hFFFF_FFFF;
    branch_taken_i = 1'b1; branch_target_i = 32'h10;
    tick();
    idle_inputs();
    tick();
    checks++; if (halted_o !== 1'b1) begin errors++; $display("FAIL mid_halt got %b exp 1", halted_o); end
    rst_i = 1'b0; branch_taken_i = 1'b1; branch_target_i = 32'h200;
    tick();
    idle_inputs();
    checks++; if (pc_o !== 32'h0 || if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0 || if_id_pc4_o !== 32'h0 || halted_o !== 1'b0) begin
      errors++; $display("FAIL mid_reset got pc %h valid %b instr %h pc4 %h halted %b exp all 0", pc_o, if_id_valid_o, if_id_instr_o, if_id_pc4_o, halted_o); end
    mem[4] = 32'h2000_0004;
    rst_i = 1'b1;
    tick();
    tick();
    checks++; if (if_id_instr_o !== 32'h2008_0005 || pc_o !== 32'h4) begin
      errors++; $display("FAIL post_reset got instr %h pc %h exp 20080005/4", if_id_instr_o, pc_o); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 | i;
    mem[0] = 32'h2008_0005;
    test_reset();
    test_stall();
    test_flush();
    test_branch();
    test_jump();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
